time_set_ctrl: RTL
==================

Name: time_set_ctrl

Overview:
- Front-panel controller that sequences the time-keeping datapath between run mode and manual set mode.
- Debounces four raw push-buttons.
- Drives the datapath's adjust, select[3:0], add and clr controls, plus a blink enable for the display of the selected digit.
- Sits between the board keys and the time-flow counter chain.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency; used only to size the internal 1 ms prescaler.
- DEB_MS, 20, consecutive stable 1 ms samples required to accept a key level.
- PULSE_W, 4, clk cycles that add_out/clr_out are held high per event.
- FIRST_SEL, 2, first selectable digit (2 = second low; millisecond digits are skipped).
- LAST_SEL, 7, last selectable digit (7 = hour high).
- TIMEOUT_MS, 10_000, idle time in SET after which the block returns to RUN.
- BLINK_MS, 250, blink half-period.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- key_mode_n  in  1  raw mode key, active-low, asynchronous to clk
- key_next_n  in  1  raw next-digit key, active-low
- key_add_n  in  1  raw increment key, active-low
- key_clr_n  in  1  raw digit-clear key, active-low
- adjust  out  1  1 = datapath counts from its clock chain (run); 0 = manual set
- select  out  4  digit index to the datapath select decoder
- add_out  out  1  increment strobe to the datapath, active-high
- clr_out  out  1  digit-clear strobe to the datapath, active-high
- blink  out  1  display enable for the selected digit; constant 1 in RUN
- set_mode  out  1  status: 1 while in SET or PULSE

Behaviour:
- Reset (async assert, sync release through a 2-flop synchronizer):
  - adjust=1, select=0, add_out=0, clr_out=0, blink=1, set_mode=0.
  - State=RUN; all counters cleared.
- Input conditioning:
  - Each raw key passes through a 2-flop synchronizer.
  - The key is sampled on a 1 ms tick from the internal prescaler (CLK_HZ/1000 cycles).
  - The debounced level changes only after DEB_MS equal consecutive samples.
  - A release-to-press transition of the debounced level yields a 1-cycle event (ev_mode, ev_next, ev_add, ev_clr).
- Event priority when several occur in the same cycle: mode > clr > add > next. Lower-priority events in that cycle are dropped.
- RUN:
  - adjust=1, select=0, blink=1.
  - ev_mode → SET, with select=FIRST_SEL and the idle timer cleared.
  - All other events are ignored.
- SET:
  - adjust=0, set_mode=1.
  - ev_next: select increments. LAST_SEL wraps to FIRST_SEL.
  - ev_add → PULSE; add_out goes high the next cycle.
  - ev_clr → PULSE; clr_out goes high the next cycle.
  - ev_mode → RUN. adjust returns to 1 in the cycle after the event.
  - The idle timer counts 1 ms ticks and is cleared by any event. On reaching TIMEOUT_MS → RUN.
  - blink toggles every BLINK_MS; the blink counter restarts at 1 on SET entry.
- PULSE:
  - Exactly one of add_out/clr_out is high for PULSE_W cycles, then low for 1 cycle (the guaranteed falling edge).
  - Then return to SET. select and adjust are unchanged throughout.
  - Events arriving during PULSE, including ev_mode, are latched in a 1-deep pending register and acted on in the first SET cycle. A second event of any kind while one is pending overwrites it.
- select changes only in SET, never in PULSE, so the strobes never straddle a select change.
- Reset during PULSE drops the strobe immediately (async) and forces RUN.

Optional Feature:
- Macro AUTO_REPEAT_EN.
- When defined: in SET, holding key_add for 500 debounced ms re-issues an add event every 100 ms while held. Each repeat goes through PULSE as normal and clears the idle timer. Releasing the key stops repeats within 1 ms.
- When undefined: one add per press only, and the hold counters are not synthesized.

Decomposition:
- Package time_ctrl_pkg:
  - state enum {RUN, SET, PULSE};
  - select constants SEL_MS_L=0 … SEL_HOUR_H=7;
  - repeat timing constants REP_DLY_MS=500, REP_PER_MS=100.
- Sub-module key_debounce (sync + sample counter + edge event), instantiated four times and sharing the 1 ms tick.

Test Plan (bench parameters: CLK_HZ=10_000, DEB_MS=3, TIMEOUT_MS=50, BLINK_MS=5):
- Reset mid-run: hold rst_n=0 with add_out forced into PULSE → adjust=1, select=0, add_out=0 in the same cycle as reset assertion.
- Bounce: key_mode_n toggles every 1 ms for 10 ms, then stays low → exactly one RUN→SET transition; select=2; adjust=0.
- Digit walk: in SET, press next 6 times → select sequence 3,4,5,6,7,2.
- Add strobe: in SET with select=4, press add → add_out high for exactly 4 cycles then low; select stays 4; state back to SET.
- Simultaneous/pending: press mode and add within the same debounced ms → only the mode action taken, RUN entered, no add_out pulse. Press mode during a clr PULSE → clr_out completes its 4 cycles, then RUN.
- Timeout, plus AUTO_REPEAT_EN build: no key for 50 ms in SET → RUN with adjust=1. Holding add for 800 ms yields 1+3=4 add_out pulses.

Source files
------------

// File: rtl/time_ctrl_pkg.sv
// time_ctrl_pkg: shared types and constants for the time_set_ctrl front panel.
//   state_t  : controller mode (RUN / SET / PULSE)
//   ev_t     : one prioritised key event per cycle
//   K_*      : index of each key in the debouncer array
//   SEL_*    : datapath digit indices
//   REP_*    : auto-repeat timing (used only when AUTO_REPEAT_EN is defined)
package time_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET   = 2'd1,
        PULSE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        EV_NONE = 3'd0,
        EV_NEXT = 3'd1,
        EV_ADD  = 3'd2,
        EV_CLR  = 3'd3,
        EV_MODE = 3'd4
    } ev_t;

    localparam int K_NEXT = 0;
    localparam int K_ADD  = 1;
    localparam int K_CLR  = 2;
    localparam int K_MODE = 3;

    localparam logic [3:0] SEL_MS_L   = 4'd0;
    localparam logic [3:0] SEL_MS_H   = 4'd1;
    localparam logic [3:0] SEL_SEC_L  = 4'd2;
    localparam logic [3:0] SEL_SEC_H  = 4'd3;
    localparam logic [3:0] SEL_MIN_L  = 4'd4;
    localparam logic [3:0] SEL_MIN_H  = 4'd5;
    localparam logic [3:0] SEL_HOUR_L = 4'd6;
    localparam logic [3:0] SEL_HOUR_H = 4'd7;

    localparam int REP_DLY_MS = 500;
    localparam int REP_PER_MS = 100;

    // Same-cycle events resolve mode > clr > add > next; the losers are dropped.
    function automatic ev_t ev_prio(input logic m, input logic c, input logic a, input logic n);
        if (m) return EV_MODE;
        if (c) return EV_CLR;
        if (a) return EV_ADD;
        if (n) return EV_NEXT;
        return EV_NONE;
    endfunction

endpackage

// File: rtl/time_set_ctrl_key_debounce.sv
// key_debounce: conditions one raw active-low push-button.
//   clk, rst_n : clock, async active-low reset (already synchronised upstream)
//   i_tick     : 1 ms sample strobe, one clk wide
//   i_key_n    : raw key, active-low, asynchronous to clk
//   o_level    : debounced level, 1 = pressed
//   o_sample   : synchronised raw level, 1 = pressed
//   o_event    : one-cycle pulse on a debounced release-to-press transition
module key_debounce #(
    parameter int DEB_MS = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_tick,
    input  logic i_key_n,
    output logic o_level,
    output logic o_sample,
    output logic o_event
);
    localparam int CW = (DEB_MS > 1) ? $clog2(DEB_MS + 1) : 1;

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_event;
    logic          w_sample;

    assign w_sample = ~r_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b11;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_event <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_key_n};
            r_event <= 1'b0;
            if (i_tick) begin
                // r_cnt counts consecutive samples that disagree with the
                // accepted level; any agreeing sample restarts the run.
                if (w_sample == r_level) begin
                    r_cnt <= '0;
                end else if (r_cnt == CW'(DEB_MS - 1)) begin
                    r_cnt   <= '0;
                    r_level <= w_sample;
                    r_event <= w_sample;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_level  = r_level;
    assign o_sample = w_sample;
    assign o_event  = r_event;

endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: front-panel controller sequencing the time datapath between
// run mode and manual set mode.
//   clk, rst_n         : system clock, async active-low reset (sync release inside)
//   key_*_n            : raw active-low keys (mode, next, add, clr)
//   adjust             : 1 = datapath runs from its clock chain, 0 = manual set
//   select[3:0]        : digit index to the datapath
//   add_out / clr_out  : PULSE_W-cycle increment / clear strobes
//   blink              : display enable of the selected digit (1 in RUN)
//   set_mode           : 1 while in SET or PULSE
// Build option: define AUTO_REPEAT_EN to re-issue add while key_add is held.
module time_set_ctrl
    import time_ctrl_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int DEB_MS     = 20,
    parameter int PULSE_W    = 4,
    parameter int FIRST_SEL  = 2,
    parameter int LAST_SEL   = 7,
    parameter int TIMEOUT_MS = 10_000,
    parameter int BLINK_MS   = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_mode_n,
    input  logic       key_next_n,
    input  logic       key_add_n,
    input  logic       key_clr_n,
    output logic       adjust,
    output logic [3:0] select,
    output logic       add_out,
    output logic       clr_out,
    output logic       blink,
    output logic       set_mode
);
    localparam int TICK_DIV = CLK_HZ / 1000;
    localparam int PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PCW = $clog2(PULSE_W + 1);
    localparam int IW  = $clog2(TIMEOUT_MS + 1);
    localparam int BW  = $clog2(BLINK_MS + 1);

    // Reset: asserts asynchronously, releases two clocks later.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    // 1 ms prescaler shared by all debouncers and timers.
    logic [PW-1:0] r_pre;
    logic          r_tick;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_pre  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_pre == PW'(TICK_DIV - 1));
            r_pre  <= (r_pre == PW'(TICK_DIV - 1)) ? '0 : r_pre + 1'b1;
        end
    end

    logic [3:0] w_key_n, w_lvl, w_smp, w_evk;
    assign w_key_n = {key_mode_n, key_clr_n, key_add_n, key_next_n};

    for (genvar k = 0; k < 4; k++) begin : g_deb
        key_debounce #(.DEB_MS(DEB_MS)) u_deb (
            .clk      (clk),
            .rst_n    (w_rst_n),
            .i_tick   (r_tick),
            .i_key_n  (w_key_n[k]),
            .o_level  (w_lvl[k]),
            .o_sample (w_smp[k]),
            .o_event  (w_evk[k])
        );
    end

    state_t         r_state, w_state_nxt;
    logic [3:0]     r_sel, w_sel_nxt;
    logic           r_clr_kind, w_clr_kind_nxt;
    logic [PCW-1:0] r_pcnt, w_pcnt_nxt;
    ev_t            r_pend, w_pend_nxt;
    ev_t            w_ev, w_act;
    logic [IW-1:0]  r_idle;
    logic [BW-1:0]  r_bcnt;
    logic           r_blink, r_adjust, r_set_mode, r_add, r_clr;
    logic           w_add_ev, w_add_nxt, w_clr_nxt;

`ifdef AUTO_REPEAT_EN
    localparam int HW = $clog2(REP_DLY_MS + 1);
    logic [HW-1:0] r_hold;
    logic          r_rep;

    // After REP_DLY_MS of debounced hold, fire and rewind by REP_PER_MS so
    // later repeats land every REP_PER_MS. The raw sample gates it so a
    // release stops repeats on the next tick, before the debounce settles.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_hold <= '0;
            r_rep  <= 1'b0;
        end else begin
            r_rep <= 1'b0;
            if (r_state == RUN || !w_smp[K_ADD] || !w_lvl[K_ADD]) begin
                r_hold <= '0;
            end else if (r_tick) begin
                if (r_hold == HW'(REP_DLY_MS - 1)) begin
                    r_rep  <= 1'b1;
                    r_hold <= HW'(REP_DLY_MS - REP_PER_MS);
                end else begin
                    r_hold <= r_hold + 1'b1;
                end
            end
        end
    end
    assign w_add_ev = w_evk[K_ADD] | r_rep;
`else
    assign w_add_ev = w_evk[K_ADD];
`endif

    assign w_ev = ev_prio(w_evk[K_MODE], w_evk[K_CLR], w_add_ev, w_evk[K_NEXT]);

    always_comb begin
        w_state_nxt    = r_state;
        w_sel_nxt      = r_sel;
        w_clr_kind_nxt = r_clr_kind;
        w_pcnt_nxt     = r_pcnt;
        w_pend_nxt     = r_pend;
        // An event latched during PULSE is served first; live events in
        // that same cycle are dropped.
        w_act          = (r_pend != EV_NONE) ? r_pend : w_ev;
        case (r_state)
            RUN: begin
                if (w_ev == EV_MODE) begin
                    w_state_nxt = SET;
                    w_sel_nxt   = 4'(FIRST_SEL);
                end
            end
            SET: begin
                w_pend_nxt = EV_NONE;
                case (w_act)
                    EV_MODE: begin
                        w_state_nxt = RUN;
                        w_sel_nxt   = 4'd0;
                    end
                    EV_CLR, EV_ADD: begin
                        w_state_nxt    = PULSE;
                        w_clr_kind_nxt = (w_act == EV_CLR);
                        w_pcnt_nxt     = '0;
                    end
                    EV_NEXT: begin
                        w_sel_nxt = (r_sel == 4'(LAST_SEL)) ? 4'(FIRST_SEL) : r_sel + 4'd1;
                    end
                    default: begin
                        if (r_idle == IW'(TIMEOUT_MS)) begin
                            w_state_nxt = RUN;
                            w_sel_nxt   = 4'd0;
                        end
                    end
                endcase
            end
            PULSE: begin
                if (w_ev != EV_NONE) w_pend_nxt = w_ev;
                // pcnt 0..PULSE_W-1 strobe high, pcnt == PULSE_W is the low cycle.
                if (r_pcnt == PCW'(PULSE_W)) w_state_nxt = SET;
                else                         w_pcnt_nxt  = r_pcnt + 1'b1;
            end
            default: begin
                w_state_nxt = RUN;
                w_sel_nxt   = 4'd0;
                w_pend_nxt  = EV_NONE;
            end
        endcase
        w_add_nxt = (w_state_nxt == PULSE) && !w_clr_kind_nxt && (w_pcnt_nxt < PCW'(PULSE_W));
        w_clr_nxt = (w_state_nxt == PULSE) &&  w_clr_kind_nxt && (w_pcnt_nxt < PCW'(PULSE_W));
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= RUN;
            r_sel      <= 4'd0;
            r_clr_kind <= 1'b0;
            r_pcnt     <= '0;
            r_pend     <= EV_NONE;
            r_adjust   <= 1'b1;
            r_set_mode <= 1'b0;
            r_add      <= 1'b0;
            r_clr      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_clr_kind <= w_clr_kind_nxt;
            r_pcnt     <= w_pcnt_nxt;
            r_pend     <= w_pend_nxt;
            r_adjust   <= (w_state_nxt == RUN);
            r_set_mode <= (w_state_nxt != RUN);
            r_add      <= w_add_nxt;
            r_clr      <= w_clr_nxt;
        end
    end

    // Idle timer runs only in SET. Any event, or any key currently down
    // (raw or debounced), counts as activity so a held key never times out.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_idle <= '0;
        end else if (r_state != SET || w_ev != EV_NONE || r_pend != EV_NONE || |{w_lvl, w_smp}) begin
            r_idle <= '0;
        end else if (r_tick && r_idle != IW'(TIMEOUT_MS)) begin
            r_idle <= r_idle + 1'b1;
        end
    end

    // Blink: held at count 1 / visible in RUN, so each SET entry restarts it.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_bcnt  <= BW'(1);
            r_blink <= 1'b1;
        end else if (r_state == RUN) begin
            r_bcnt  <= BW'(1);
            r_blink <= 1'b1;
        end else if (r_tick) begin
            if (r_bcnt == BW'(BLINK_MS)) begin
                r_bcnt  <= BW'(1);
                r_blink <= ~r_blink;
            end else begin
                r_bcnt <= r_bcnt + 1'b1;
            end
        end
    end

    assign adjust   = r_adjust;
    assign select   = r_sel;
    assign add_out  = r_add;
    assign clr_out  = r_clr;
    assign blink    = r_adjust | r_blink;
    assign set_mode = r_set_mode;

endmodule
